// File: rtl/sample_pingpong_ram.sv
// Double-buffered (ping-pong) complex sample store between the sample front end and the FFT.
// The writer fills one bank with a frame of 2**ADDR_W words {re, im} while the consumer
// randomly reads the other, completed bank. Banks swap via frame-complete / rd_release.
// Build option: define SAMPLE_PINGPONG_BITREV_EN to store each frame in bit-reversed index
// order (for an in-place DIT FFT); otherwise frames are stored in natural order.
module sample_pingpong_ram #(
   parameter int unsigned WIDTH  = 20,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_valid,
   input  logic [2*WIDTH-1:0]  wr_data,
   output logic                wr_ready,
   output logic                frame_valid,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [2*WIDTH-1:0]  rd_data,
   input  logic                rd_release,
   output logic                wr_bank,
   output logic                rd_bank,
   output logic [CNT_W-1:0]    drop_cnt,
   output logic                overflow
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   // Two banks back to back; physical address is {bank, index}. Contents are not reset.
   logic [2*WIDTH-1:0] mem_q [2*Depth];

   logic               wsel_q, wsel_d;
   logic               rsel_q, rsel_d;
   logic [1:0]         full_q, full_d;
   logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
   logic [2*WIDTH-1:0] rd_data_q, rd_data_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;

   logic               accept;
   logic               drop;
   logic               frame_done;
   logic               release_ok;
   logic [ADDR_W-1:0]  waddr;

   assign wr_ready    = ~full_q[wsel_q];
   assign frame_valid = full_q[rsel_q];
   assign wr_bank     = wsel_q;
   assign rd_bank     = rsel_q;
   assign rd_data     = rd_data_q;
   assign drop_cnt    = drop_cnt_q;
   assign overflow    = overflow_q;

   // Write index within the bank: natural or bit-reversed frame order.
   always_comb begin
      waddr = wcnt_q;
`ifdef SAMPLE_PINGPONG_BITREV_EN
      for (int i = 0; i < ADDR_W; i++) begin
         waddr[i] = wcnt_q[ADDR_W-1-i];
      end
`endif
   end

   // Handshake decode and next-state for bank ownership, counters and read data.
   always_comb begin
      accept     = wr_valid & wr_ready;
      drop       = wr_valid & ~wr_ready;
      frame_done = accept && (wcnt_q == {ADDR_W{1'b1}});
      release_ok = rd_release & full_q[rsel_q];

      wsel_d     = wsel_q;
      rsel_d     = rsel_q;
      full_d     = full_q;
      wcnt_d     = wcnt_q;
      rd_data_d  = rd_data_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;

      if (accept) begin
         wcnt_d = wcnt_q + ADDR_W'(1);
      end
      // Writer never owns a full bank, so a same-cycle set and clear always hit different flags.
      if (frame_done) begin
         full_d[wsel_q] = 1'b1;
         wsel_d         = ~wsel_q;
      end
      if (release_ok) begin
         full_d[rsel_q] = 1'b0;
         rsel_d         = ~rsel_q;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
      end
      // Read uses the pre-release bank select.
      if (rd_en) begin
         rd_data_d = mem_q[{rsel_q, rd_addr}];
      end
   end

   // Sample storage write port.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[{wsel_q, waddr}] <= wr_data;
      end
   end

   // Control state and registered read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsel_q     <= 1'b0;
         rsel_q     <= 1'b0;
         full_q     <= 2'b00;
         wcnt_q     <= '0;
         rd_data_q  <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wsel_q     <= wsel_d;
         rsel_q     <= rsel_d;
         full_q     <= full_d;
         wcnt_q     <= wcnt_d;
         rd_data_q  <= rd_data_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_sample_pingpong_ram.sv
// Directed bench for sample_pingpong_ram (WIDTH=8, ADDR_W=3, CNT_W=2).
// Works in both builds; SAMPLE_PINGPONG_BITREV_EN changes the expected storage order.
module tb_sample_pingpong_ram;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned CNT_W  = 2;

   logic                clk;
   logic                rst_n;
   logic                wr_valid;
   logic [2*WIDTH-1:0]  wr_data;
   logic                wr_ready;
   logic                frame_valid;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [2*WIDTH-1:0]  rd_data;
   logic                rd_release;
   logic                wr_bank;
   logic                rd_bank;
   logic [CNT_W-1:0]    drop_cnt;
   logic                overflow;

   int n_chk;
   int n_fail;

   sample_pingpong_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .frame_valid (frame_valid),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_release  (rd_release),
      .wr_bank     (wr_bank),
      .rd_bank     (rd_bank),
      .drop_cnt    (drop_cnt),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample index held at a given read address after pushing indices 0..7 in order.
   function automatic logic [2:0] stored_idx(input logic [2:0] a);
`ifdef SAMPLE_PINGPONG_BITREV_EN
      return {a[0], a[1], a[2]};
`else
      return a;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push n samples base+0 .. base+n-1, one per cycle.
   task automatic push(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = base + 16'(i);
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
      chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
      chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
      chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      rd_release = 1'b0;
      repeat (3) tick();
      chk_reset_vals("rst0");
      rst_n = 1'b1;
      tick();

      // Frame 0 into bank 0, data = index.
      push(8, 16'h0000);
      chk("f0_frame_valid", 32'(frame_valid), 32'd1);
      chk("f0_wr_bank", 32'(wr_bank), 32'd1);
      chk("f0_rd_bank", 32'(rd_bank), 32'd0);
      chk("f0_wr_ready", 32'(wr_ready), 32'd1);
      for (int a = 0; a < 8; a++) begin
         rd_chk("f0_read", 3'(a), 16'(stored_idx(3'(a))));
      end
      tick();
      chk("rd_hold", 32'(rd_data), 32'(stored_idx(3'd7)));

      // Frame 1 into bank 1 with no release: both banks full.
      push(8, 16'h0010);
      chk("f1_wr_ready", 32'(wr_ready), 32'd0);
      chk("f1_wr_bank", 32'(wr_bank), 32'd0);
      chk("f1_rd_bank", 32'(rd_bank), 32'd0);

      // Drops while stalled; saturate at 3 with CNT_W=2.
      for (int d = 1; d <= 5; d++) begin
         wr_valid = 1'b1;
         wr_data  = 16'hffff;
         tick();
         chk("drop_cnt", 32'(drop_cnt), (d < 3) ? 32'(d) : 32'd3);
      end
      wr_valid = 1'b0;
      chk("overflow", 32'(overflow), 32'd1);
      chk("drop_wr_bank", 32'(wr_bank), 32'd0);
      rd_chk("drop_mem_b0a2", 3'd2, 16'(stored_idx(3'd2)));
      rd_chk("drop_mem_b0a0", 3'd0, 16'h0000);

      // Release bank 0.
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel_wr_ready", 32'(wr_ready), 32'd1);
      chk("rel_wr_bank", 32'(wr_bank), 32'd0);
      chk("rel_rd_bank", 32'(rd_bank), 32'd1);
      chk("rel_frame_valid", 32'(frame_valid), 32'd1);
      rd_chk("b1_read_a0", 3'd0, 16'h0010 + 16'(stored_idx(3'd0)));
      rd_chk("b1_read_a5", 3'd5, 16'h0010 + 16'(stored_idx(3'd5)));

      // Frame 2 into freed bank 0; 8th sample coincides with release and a read.
      push(7, 16'h0020);
      chk("f2_wr_ready_mid", 32'(wr_ready), 32'd1);
      wr_valid   = 1'b1;
      wr_data    = 16'h0027;
      rd_release = 1'b1;
      rd_en      = 1'b1;
      rd_addr    = 3'd1;
      tick();
      wr_valid   = 1'b0;
      rd_release = 1'b0;
      rd_en      = 1'b0;
      chk("sim_rd_pre_release", 32'(rd_data), 32'(16'h0010 + 16'(stored_idx(3'd1))));
      chk("sim_rd_bank", 32'(rd_bank), 32'd0);
      chk("sim_wr_bank", 32'(wr_bank), 32'd1);
      chk("sim_frame_valid", 32'(frame_valid), 32'd1);
      chk("sim_wr_ready", 32'(wr_ready), 32'd1);
      rd_chk("f2_read_a3", 3'd3, 16'h0020 + 16'(stored_idx(3'd3)));

      // Release bank 0; bank 1 is empty so frame_valid drops.
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel2_rd_bank", 32'(rd_bank), 32'd1);
      chk("rel2_frame_valid", 32'(frame_valid), 32'd0);
      // Release while nothing valid is ignored.
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("ign_rd_bank", 32'(rd_bank), 32'd1);
      chk("ign_frame_valid", 32'(frame_valid), 32'd0);
      chk("ign_wr_ready", 32'(wr_ready), 32'd1);

      // Partial frame then asynchronous reset.
      push(5, 16'h0030);
      chk("part_wr_bank", 32'(wr_bank), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst1");
      tick();
      rst_n = 1'b1;
      tick();

      // Fresh frame lands in bank 0 from index 0.
      push(8, 16'h0040);
      chk("f4_frame_valid", 32'(frame_valid), 32'd1);
      chk("f4_wr_bank", 32'(wr_bank), 32'd1);
      chk("f4_rd_bank", 32'(rd_bank), 32'd0);
      rd_chk("f4_read_a0", 3'd0, 16'h0040);
      rd_chk("f4_read_a7", 3'd7, 16'h0047);
      rd_chk("f4_read_a6", 3'd6, 16'h0040 + 16'(stored_idx(3'd6)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
